// File: rtl/ic_resp_merge.sv
// Round-robin N-to-1 response merger with a single registered output beat tagged by source index.
// Optional IC_RESP_LOCK_EN: keeps the grant on one port until it presents a last beat.
module ic_resp_merge #(
   parameter  int NumIn     = 32,
   parameter  int DataWidth = 64,
   localparam int IdWidth   = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumIn-1:0][DataWidth-1:0]  in_data_i,
   input  logic [NumIn-1:0]                 in_valid_i,
`ifdef IC_RESP_LOCK_EN
   input  logic [NumIn-1:0]                 in_last_i,
`endif
   output logic [NumIn-1:0]                 in_ready_o,
   output logic [DataWidth-1:0]             out_data_o,
   output logic [IdWidth-1:0]               out_id_o,
   output logic                             out_valid_o,
`ifdef IC_RESP_LOCK_EN
   output logic                             out_last_o,
`endif
   input  logic                             out_ready_i
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [DataWidth-1:0] r_data;
   logic [IdWidth-1:0]   r_id;
   logic [IdWidth-1:0]   r_rr;
   logic [IdWidth-1:0]   w_rr_next;

   logic [IdWidth-1:0]   w_high_idx;
   logic                 w_high_found;
   logic [IdWidth-1:0]   w_low_idx;
   logic                 w_any_valid;
   logic [IdWidth-1:0]   w_rr_grant;
   logic [IdWidth-1:0]   w_grant;
   logic                 w_grant_valid;
   logic                 w_load_en;
   logic                 w_take;

   // Descending scan so the final assignment is the lowest matching index;
   // "high" covers indices at or above the pointer, "low" is the wrapped fallback.
   always_comb begin
      w_high_idx   = '0;
      w_high_found = 1'b0;
      w_low_idx    = '0;
      w_any_valid  = 1'b0;
      for (int i = NumIn - 1; i >= 0; i--) begin
         if (in_valid_i[i]) begin
            w_low_idx   = IdWidth'(i);
            w_any_valid = 1'b1;
            if (IdWidth'(i) >= r_rr) begin
               w_high_idx   = IdWidth'(i);
               w_high_found = 1'b1;
            end
         end
      end
   end

   assign w_rr_grant = w_high_found ? w_high_idx : w_low_idx;

`ifdef IC_RESP_LOCK_EN
   logic               r_locked;
   logic [IdWidth-1:0] r_lock_idx;
   logic               r_last;

   assign w_grant       = r_locked ? r_lock_idx : w_rr_grant;
   assign w_grant_valid = r_locked ? in_valid_i[r_lock_idx] : w_any_valid;
`else
   assign w_grant       = w_rr_grant;
   assign w_grant_valid = w_any_valid;
`endif

   // Gating with rst_ni keeps every ready low for the whole reset window.
   assign w_load_en = rst_ni && (!out_valid_o || out_ready_i);
   assign w_take    = w_load_en && w_grant_valid;

   generate
      for (genvar gi = 0; gi < NumIn; gi++) begin : g_ready
         assign in_ready_o[gi] = w_take && (w_grant == IdWidth'(gi));
      end
   endgenerate

   assign w_rr_next = (w_grant == IdWidth'(NumIn - 1)) ? '0 : w_grant + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_load_en) begin
         w_state_next = w_take ? S_FULL : S_EMPTY;
      end
   end

   always_comb begin
      out_valid_o = (r_state == S_FULL);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data <= '0;
         r_id   <= '0;
      end else if (w_take) begin
         r_data <= in_data_i[w_grant];
         r_id   <= w_grant;
      end
   end

`ifdef IC_RESP_LOCK_EN
   // The pointer only moves once a burst completes, so a locked port keeps its turn.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr       <= '0;
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
         r_last     <= 1'b0;
      end else if (w_take) begin
         r_locked   <= !in_last_i[w_grant];
         r_lock_idx <= w_grant;
         r_last     <= in_last_i[w_grant];
         if (in_last_i[w_grant]) begin
            r_rr <= w_rr_next;
         end
      end
   end

   assign out_last_o = r_last;
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr <= '0;
      end else if (w_take) begin
         r_rr <= w_rr_next;
      end
   end
`endif

   assign out_data_o = r_data;
   assign out_id_o   = r_id;

endmodule

// File: doc/ic_resp_merge.md
Name: ic_resp_merge

Overview:
- N-to-1 response merger for the interconnect return path: collects responses from NumIn target-side ports and serialises them onto one requester-facing port.
- Round-robin arbitration; the winner's beat is captured into a single output register.
- Each beat carries a source index so the requester end can route it back.
- Complements the request-direction interconnect, which fans requests out; this block fans responses in.

Parameters:
- NumIn, 32, number of response input ports (>= 1)
- DataWidth, 64, beat width; matches ic_pkg::data_t
- IdWidth, (NumIn > 1) ? $clog2(NumIn) : 1, derived width of the source index; not overridable

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- in_data_i  input  NumIn x DataWidth  per-port response data
- in_valid_i  input  NumIn  per-port valid
- in_ready_o  output  NumIn  per-port ready
- out_data_o  output  DataWidth  merged response data, registered
- out_id_o  output  IdWidth  index of the source port for the current beat, registered
- out_valid_o  output  1  merged valid, registered
- out_ready_i  input  1  downstream ready

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous, active-low.
- Reset values: out_valid_o=0, out_data_o=0, out_id_o=0, round-robin pointer rr_q=0. All in_ready_o are 0 while rst_ni is low.
- Output register: one entry, states EMPTY and FULL; FULL == out_valid_o.
- load_en = !out_valid_o || out_ready_i. This gives full throughput: one beat per cycle when downstream is always ready.
- Arbitration (combinational):
  - grant = lowest index i with in_valid_i[i]=1, searching rr_q, rr_q+1, ..., NumIn-1, 0, ..., rr_q-1 (wraps).
  - any_valid = OR of in_valid_i.
- Ready generation: in_ready_o[i] = load_en && any_valid && (i == grant). At most one bit is set per cycle. Ready may depend on valid; valid must never depend on ready.
- Transfer on input i: in_valid_i[i] && in_ready_o[i]. On that clock edge:
  - out_data_o <= in_data_i[grant]
  - out_id_o <= grant
  - out_valid_o <= 1
  - rr_q <= (grant == NumIn-1) ? 0 : grant+1. Wrap is explicit, so a non-power-of-2 NumIn is legal.
- If load_en=1 and no input is valid: out_valid_o <= 0. out_data_o and out_id_o hold their previous value (don't-care content).
- Latency: one cycle from input handshake to out_valid_o.
- Backpressure: while out_valid_o && !out_ready_i, out_data_o, out_id_o and out_valid_o are held stable and all in_ready_o=0.
- Simultaneous drain and load: when FULL and out_ready_i=1, the register reloads in the same cycle with no bubble.
- NumIn=1: grant is always 0, out_id_o is always 0, rr_q stays 0.
- Reset mid-operation: an in-flight beat in the output register is discarded; the next grant starts from index 0.
- Fairness: a continuously valid port is granted within NumIn accepted beats.

Optional Feature:
Macro IC_RESP_LOCK_EN.
- Defined:
  - Adds port in_last_i (input, NumIn) and port out_last_o (output, 1, registered, reset 0).
  - Adds state locked_q and lock_idx_q, both reset to 0.
  - Accepting a beat with in_last_i[grant]=0 sets locked_q=1 and lock_idx_q=grant.
  - While locked_q=1, grant is forced to lock_idx_q. Other ports get no ready even if lock_idx_q is idle.
  - Accepting a beat with last=1 clears locked_q.
  - rr_q advances only on a last beat.
  - out_last_o follows in_last_i of the granted port with the same timing as out_data_o.
- Undefined: no last ports; every beat is arbitrated independently, as described above.

Test Plan:
- Reset: drive in_valid_i=all-ones, pulse rst_ni low asynchronously between clock edges -> out_valid_o=0 and in_ready_o=0 immediately. First beat after release has out_id_o=0.
- Single source: only port 5 valid, data 0x0000_0000_0000_DEAD, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0x...DEAD, out_id_o=5. Following cycle out_valid_o=0.
- Full throughput: all 32 ports continuously valid, out_ready_i=1 -> out_id_o sequence 0,1,...,31,0,1, one beat per cycle with no bubbles.
- Backpressure: hold out_ready_i=0 for 3 cycles while FULL with id 7 -> out_data_o and out_id_o stable, all in_ready_o=0. Release -> id 7 drains and id 8 loads in the same cycle.
- Wrap: rr_q=31, ports 31 and 0 valid -> grants 31 then 0. NumIn=3 build: ports 0,1,2 valid -> 0,1,2,0.
- Lock (IC_RESP_LOCK_EN): port 2 sends 3 beats with last on the third, port 3 valid throughout -> out_id_o=2,2,2,3 and out_last_o=0,0,1,x.
